// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding and
// bit-counter width derived from the word width.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Counter only has to reach width-1, so $clog2(width) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/word_shift_reg.sv
// Loadable shift register built from per-bit register cells; shifts toward the
// emitting end (bit 0 when MsbFirst=0, bit Width-1 when MsbFirst=1).
module word_shift_reg
    import word_serializer_pkg::*;
#(
    parameter int unsigned Width    = 16,
    parameter bit          MsbFirst = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] w_q;

    for (genvar i = 0; i < Width; i++) begin : g_cell
        logic w_shift_in;
        logic r_bit;

        // Vacated end fills with zero.
        if (MsbFirst) begin : g_msb
            if (i == 0) begin : g_edge
                assign w_shift_in = 1'b0;
            end else begin : g_inner
                assign w_shift_in = w_q[i-1];
            end
        end else begin : g_lsb
            if (i == Width - 1) begin : g_edge
                assign w_shift_in = 1'b0;
            end else begin : g_inner
                assign w_shift_in = w_q[i+1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_bit <= 1'b0;
            end else if (i_load) begin
                r_bit <= i_data[i];
            end else if (i_shift_en) begin
                r_bit <= w_shift_in;
            end
        end

        assign w_q[i] = r_bit;
    end

    assign o_q = w_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and emits it
// one bit per clock as a bit/load pair, then pulses done for one cycle.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_out_hold,
    output logic             o_out_bit,
    output logic             o_out_load,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned      CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
    localparam bit               MsbEmit = (MSB_FIRST != 0);

    state_e           r_state;
    state_e           w_state_next;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_next;
    logic             w_load;
    logic             w_shift_en;
    logic [WIDTH-1:0] w_shreg;

    word_shift_reg #(
        .Width    (WIDTH),
        .MsbFirst (MsbEmit)
    ) u_shift_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_shift_en (w_shift_en),
        .i_data     (i_in_data),
        .o_q        (w_shreg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;
        o_in_ready   = 1'b0;
        o_out_load   = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            StIdle: begin
                // Ready is masked while reset is asserted.
                o_in_ready = rst_n;
                if (i_in_valid && rst_n) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                o_busy     = 1'b1;
                o_out_load = !i_out_hold;
                if (!i_out_hold) begin
                    w_shift_en = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_out_bit = (r_state == StShift) ? (MsbEmit ? w_shreg[WIDTH-1] : w_shreg[0]) : 1'b0;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: LSB-first and MSB-first serializers driven in parallel
// and compared cycle by cycle against a word/bit-index reference model.
module tb_word_serializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_hold = 1'b0;
    logic [W-1:0] in_data = '0;

    logic rdy_l, bit_l, load_l, busy_l, done_l;
    logic rdy_m, bit_m, load_m, busy_m, done_m;

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0] chain_l;
    logic [W-1:0] chain_m;
    logic [9:0]   obs;
    logic [9:0]   exp_v;

    localparam logic [9:0] IdleV  = 10'b1000_1000_00;
    localparam logic [9:0] ResetV = 10'b0000_0000_00;

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (rdy_l),
        .i_in_data  (in_data),
        .i_out_hold (out_hold),
        .o_out_bit  (bit_l),
        .o_out_load (load_l),
        .o_busy     (busy_l),
        .o_done     (done_l)
    );

    word_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (rdy_m),
        .i_in_data  (in_data),
        .i_out_hold (out_hold),
        .o_out_bit  (bit_m),
        .o_out_load (load_m),
        .o_busy     (busy_m),
        .o_done     (done_m)
    );

    assign obs = {rdy_l, busy_l, done_l, load_l, rdy_m, busy_m, done_m, load_m, bit_l, bit_m};

    // Downstream 1-bit register chains capturing on out_load.
    always @(posedge clk) begin
        if (load_l) chain_l <= {bit_l, chain_l[W-1:1]};
        if (load_m) chain_m <= {chain_m[W-2:0], bit_m};
    end

    // Sends one word and checks every cycle up to and including the done cycle.
    task automatic send_word(input logic [W-1:0] data, input logic [31:0] hold_mask,
                             input bit keep_valid, input string name, output int done_cyc);
        int  k;
        int  cyc;
        logic hold;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        out_hold = 1'($urandom);
        #1;
        n_checks++;
        if (obs !== IdleV) begin
            n_fail++;
            $display("FAIL %s accept: got %b want %b", name, obs, IdleV);
        end
        k   = 0;
        cyc = 1;
        while (k < W && cyc < 64) begin
            @(negedge clk);
            in_valid = keep_valid ? 1'b1 : 1'($urandom);
            in_data  = W'($urandom);
            hold     = hold_mask[cyc % 32];
            out_hold = hold;
            #1;
            exp_v = {1'b0, 1'b1, 1'b0, !hold, 1'b0, 1'b1, 1'b0, !hold, data[k], data[W-1-k]};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d bit %0d: got %b want %b", name, cyc, k, obs, exp_v);
            end
            if (!hold) k++;
            cyc++;
        end
        if (k < W) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: sent %0d bits, want %0d", name, k, W);
        end
        @(negedge clk);
        in_valid = keep_valid;
        out_hold = 1'($urandom);
        #1;
        n_checks++;
        if (obs !== 10'b0110_0110_00) begin
            n_fail++;
            $display("FAIL %s done cycle %0d: got %b want %b", name, cyc, obs, 10'b0110_0110_00);
        end
        done_cyc = cyc;
        n_checks++;
        if (chain_l !== data || chain_m !== data) begin
            n_fail++;
            $display("FAIL %s chain: got lsb %b msb %b want %b", name, chain_l, chain_m, data);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 4'b1111;
        out_hold = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (obs !== ResetV) begin
            n_fail++;
            $display("FAIL reset hold: got %b want %b", obs, ResetV);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_checks++;
        if (obs !== IdleV) begin
            n_fail++;
            $display("FAIL reset release: got %b want %b", obs, IdleV);
        end
    endtask

    task automatic test_basic();
        int dc;
        send_word(4'b1011, 32'h0, 1'b0, "basic", dc);
        n_checks++;
        if (dc !== 5) begin
            n_fail++;
            $display("FAIL basic done cycle: got %0d want 5", dc);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== IdleV) begin
            n_fail++;
            $display("FAIL basic ready cycle 6: got %b want %b", obs, IdleV);
        end
    endtask

    task automatic test_hold();
        int dc;
        send_word(4'b1011, 32'h0000_000C, 1'b0, "hold", dc);
        n_checks++;
        if (dc !== 7) begin
            n_fail++;
            $display("FAIL hold done cycle: got %0d want 7", dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        send_word(4'b0110, 32'h0, 1'b1, "b2b first", dc);
        send_word(4'b1001, 32'h0, 1'b0, "b2b second", dc);
        n_checks++;
        if (dc !== 5) begin
            n_fail++;
            $display("FAIL b2b done cycle: got %0d want 5", dc);
        end
    endtask

    task automatic test_reset_mid_word();
        int dc;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        out_hold = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== ResetV) begin
            n_fail++;
            $display("FAIL midreset async: got %b want %b", obs, ResetV);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (obs !== IdleV) begin
                n_fail++;
                $display("FAIL midreset idle %0d: got %b want %b", i, obs, IdleV);
            end
            @(negedge clk);
        end
        send_word(4'b0001, 32'h0, 1'b0, "after reset", dc);
    endtask

    task automatic test_idle_hold();
        in_valid = 1'b0;
        out_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_data = W'($urandom);
            #1;
            n_checks++;
            if (obs !== IdleV) begin
                n_fail++;
                $display("FAIL idle hold %0d: got %b want %b", i, obs, IdleV);
            end
        end
        out_hold = 1'b0;
    endtask

    task automatic test_random();
        int          dc;
        logic [31:0] mask;
        bit          keep;
        int          holds;
        for (int i = 0; i < 20; i++) begin
            mask  = $urandom & $urandom;
            keep  = (i != 19) ? 1'($urandom) : 1'b0;
            holds = 0;
            send_word(W'($urandom), mask, keep, "random", dc);
            // Done cycle equals WIDTH + 1 plus one per hold cycle seen.
            for (int c = 1; c < dc; c++) holds += int'(mask[c % 32]);
            n_checks++;
            if (dc !== W + 1 + holds) begin
                n_fail++;
                $display("FAIL random latency: got %0d want %0d", dc, W + 1 + holds);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_mid_word();
        test_idle_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parallel-to-serial transmitter that accepts one WIDTH-bit word over a valid/ready handshake and emits it one bit per clock as an (out_bit, out_load) pair. The pair drives the in/load inputs of a downstream my_1_bit_register, or a chain of them. It is the sending end of the bit/load interface those registers capture from. A one-cycle done pulse marks the end of each word.

Parameters:
WIDTH, 16, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 0, 0 = emit bit 0 first; 1 = emit bit WIDTH-1 first.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in_data holds a word to send.
in_ready  output  1  serializer can accept a word.
in_data  input  WIDTH  word to serialize.
out_hold  input  1  downstream stall; pauses shifting.
out_bit  output  1  current serial bit.
out_load  output  1  out_bit is valid and must be captured at this edge.
busy  output  1  a word is in flight (SHIFT or DONE).
done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; shift register and bit counter cleared.
  - in_ready=0, out_bit=0, out_load=0, busy=0, done=0 while rst_n is low.
  - in_ready=1 from the first cycle after release.
- Reset mid-word: the partial word is discarded, no done pulse is produced, and no further out_load follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - At an edge with in_valid=1: capture in_data, clear the counter, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - out_bit = shreg[0] if MSB_FIRST=0, else shreg[WIDTH-1].
  - out_load = !out_hold (combinational).
  - Edge with out_load=1: shift by one toward the emitting end, counter +1. If the counter was WIDTH-1, go to DONE.
  - Edge with out_hold=1: shreg, counter and state hold; out_bit stays stable.
- DONE:
  - done=1, busy=1, in_ready=0, out_load=0.
  - Unconditionally returns to IDLE after one cycle.
- out_bit=0 in IDLE and DONE.
- in_valid is ignored whenever in_ready=0; in_data is sampled only at the accept edge.
- out_hold has no effect outside SHIFT.
- Latency with no hold, accept at edge E0:
  - bits on cycles 1..WIDTH, each captured at edges E1..EWIDTH;
  - done on cycle WIDTH+1;
  - in_ready=1 on cycle WIDTH+2.
  - Throughput: one word per WIDTH+2 cycles.
  - Each hold cycle adds exactly one cycle.
- Counter width is $clog2(WIDTH). Counter wrap is never reached because the FSM exits SHIFT at WIDTH-1.
- Exactly WIDTH out_load cycles per accepted word, never more or fewer.

Decomposition:
- Shared package word_serializer_pkg:
  - state enum typedef (IDLE, SHIFT, DONE);
  - localparam CNT_W = $clog2(WIDTH), exported as a function of WIDTH.
- One natural sub-module: word_shift_reg, a WIDTH-bit loadable shift register with load, shift_en and direction parameter, built from per-bit register cells. The FSM and counter stay in word_serializer.

Test Plan:
- WIDTH=4, MSB_FIRST=0, accept 4'b1011 at E0, out_hold=0:
  - out_bit 1,1,0,1 with out_load=1 on cycles 1-4;
  - done=1 on cycle 5 only; in_ready=1 on cycle 6.
- Same word with out_hold=1 on cycles 2-3:
  - out_load=0 and out_bit holds 1 during the hold;
  - bit sequence unchanged; done on cycle 7.
- MSB_FIRST=1, 4'b1011 -> out_bit 1,0,1,1. Four chained my_1_bit_register cells loaded by out_load hold the word 4'b1011 after done.
- in_valid held high with 4'b0110, then 4'b1001:
  - first word accepted at E0, second at E6;
  - in_data changes during E1-E5 have no effect;
  - sequence 0,1,1,0,1,0,0,1.
- rst_n low for 1 cycle after 2 bits of 4'b1111:
  - all outputs 0 immediately (asynchronous);
  - no done; in_ready=1 after release;
  - a new word 4'b0001 then serializes cleanly as 1,0,0,0.
- out_hold=1 and in_valid=0 in IDLE -> no out_load and no state change over 10 cycles.
